// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file.
//
// Register 0 reads as zero and ignores writes; registers 1..NREG-1 are
// stored. Two writeback ports, NRD combinational read ports with optional
// same-cycle write-to-read forwarding, a per-register busy scoreboard for
// the issue stage, and a sequential clear engine that zeroes the array
// after reset (when CLR_ON_RST=1).
//
// Handshake: there is no per-transaction valid/ready pair. "ready" is a
// level: while it is high, writes and allocs presented on a rising edge
// take effect and read data/busy outputs are valid. While it is low,
// writes and allocs are dropped and reads return 0 / not-busy.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   ready     block accepts writes/allocs, reads valid (state == IDLE)
//   rs        NRD read addresses, port k at [k*AW +: AW]
//   rs_out    NRD read data, port k at [k*XLEN +: XLEN]
//   rs_busy   busy flag of the register addressed by each read port
//   rd0_w/rd0/rd0_in   write port 0 (enable, address, data)
//   rd1_w/rd1/rd1_in   write port 1 (enable, address, data); wins ties
//   alloc_w/alloc_rd   mark a destination register busy
//
// The FSM has two states and "ready" is exactly (state == IDLE), so the
// ready output doubles as the state observation point.
module regfile_mp #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int NRD        = 2,
  parameter int BYPASS     = 1,
  parameter int CLR_ON_RST = 1,
  localparam int AW        = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic [NRD*AW-1:0]   rs,
  output logic [NRD*XLEN-1:0] rs_out,
  output logic [NRD-1:0]      rs_busy,
  input  logic                rd0_w,
  input  logic [AW-1:0]       rd0,
  input  logic [XLEN-1:0]     rd0_in,
  input  logic                rd1_w,
  input  logic [AW-1:0]       rd1,
  input  logic [XLEN-1:0]     rd1_in,
  input  logic                alloc_w,
  input  logic [AW-1:0]       alloc_rd
);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [AW-1:0]      clr_idx;
  logic [XLEN-1:0]    regs [1:NREG-1];
  logic [NREG-1:0]    busy;

  // Effective (qualified) write and alloc strobes. Register 0 is never a
  // target, and nothing lands while in CLEAR or while reset is asserted.
  logic we0;
  logic we1;
  logic al;

  assign we0 = ready && !rst && rd0_w   && (rd0 != '0);
  assign we1 = ready && !rst && rd1_w   && (rd1 != '0);
  assign al  = ready && !rst && alloc_w && (alloc_rd != '0);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  // The clear engine leaves CLEAR on the edge that zeroes the last entry.
  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_idx == AW'(NREG - 1)) begin
      state_nxt = IDLE;
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ready = (state == IDLE);
  end

  // Clear index starts at 1 because entry 0 is not stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_idx <= AW'(1);
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
    end
  end

  // Array: no reset term, so contents survive reset when CLR_ON_RST=0.
  // Port 1 is written after port 0 so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        regs[clr_idx] <= '0;
      end else begin
        if (we0) regs[rd0] <= rd0_in;
        if (we1) regs[rd1] <= rd1_in;
      end
    end
  end

  // Scoreboard: a write retires a busy register; an alloc on the same
  // edge is applied last so the register stays busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (we0) busy[rd0]      <= 1'b0;
      if (we1) busy[rd1]      <= 1'b0;
      if (al)  busy[alloc_rd] <= 1'b1;
    end
  end

  // ---------------- Read ports ----------------
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          byp0;
    logic          byp1;
    logic          live;

    assign addr = rs[k*AW +: AW];
    assign live = ready && (addr != '0);
    assign byp0 = (BYPASS != 0) && we0 && (rd0 == addr);
    assign byp1 = (BYPASS != 0) && we1 && (rd1 == addr);

    // A forwarded read reflects the post-edge scoreboard: the write clears
    // busy unless an alloc to the same register re-sets it.
    assign rs_out[k*XLEN +: XLEN] = !live ? '0 :
                                    byp1  ? rd1_in :
                                    byp0  ? rd0_in :
                                            regs[addr];
    assign rs_busy[k] = !live          ? 1'b0 :
                        (byp0 || byp1) ? (al && (alloc_rd == addr)) :
                                         busy[addr];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp.
//
// Three instances share one clock:
//   dut_a  NREG=32 NRD=2 BYPASS=1 CLR_ON_RST=1
//   dut_b  NREG=32 NRD=2 BYPASS=0 CLR_ON_RST=1  (same stimulus as dut_a)
//   dut_c  NREG=16 NRD=4 BYPASS=1 CLR_ON_RST=0
// Inputs change 1 time unit after a rising edge; outputs are sampled one
// further unit later, well away from the next edge.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---- dut_a / dut_b shared stimulus ----
  logic        rst      = 1'b1;
  logic [9:0]  rs_ab    = '0;
  logic        rd0_w    = 1'b0;
  logic [4:0]  rd0      = '0;
  logic [31:0] rd0_in   = '0;
  logic        rd1_w    = 1'b0;
  logic [4:0]  rd1      = '0;
  logic [31:0] rd1_in   = '0;
  logic        alloc_w  = 1'b0;
  logic [4:0]  alloc_rd = '0;

  logic        ready_a, ready_b;
  logic [63:0] rs_out_a, rs_out_b;
  logic [1:0]  rs_busy_a, rs_busy_b;

  // ---- dut_c stimulus ----
  logic         rst_c      = 1'b1;
  logic [15:0]  rs_c       = '0;
  logic         rd0_w_c    = 1'b0;
  logic [3:0]   rd0_c      = '0;
  logic [31:0]  rd0_in_c   = '0;
  logic         rd1_w_c    = 1'b0;
  logic [3:0]   rd1_c      = '0;
  logic [31:0]  rd1_in_c   = '0;
  logic         alloc_w_c  = 1'b0;
  logic [3:0]   alloc_rd_c = '0;

  logic         ready_c;
  logic [127:0] rs_out_c;
  logic [3:0]   rs_busy_c;

  int checks = 0;
  int errors = 0;

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1), .CLR_ON_RST(1)) dut_a (
    .clk(clk), .rst(rst), .ready(ready_a), .rs(rs_ab), .rs_out(rs_out_a),
    .rs_busy(rs_busy_a), .rd0_w(rd0_w), .rd0(rd0), .rd0_in(rd0_in),
    .rd1_w(rd1_w), .rd1(rd1), .rd1_in(rd1_in), .alloc_w(alloc_w),
    .alloc_rd(alloc_rd)
  );

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(0), .CLR_ON_RST(1)) dut_b (
    .clk(clk), .rst(rst), .ready(ready_b), .rs(rs_ab), .rs_out(rs_out_b),
    .rs_busy(rs_busy_b), .rd0_w(rd0_w), .rd0(rd0), .rd0_in(rd0_in),
    .rd1_w(rd1_w), .rd1(rd1), .rd1_in(rd1_in), .alloc_w(alloc_w),
    .alloc_rd(alloc_rd)
  );

  regfile_mp #(.XLEN(32), .NREG(16), .NRD(4), .BYPASS(1), .CLR_ON_RST(0)) dut_c (
    .clk(clk), .rst(rst_c), .ready(ready_c), .rs(rs_c), .rs_out(rs_out_c),
    .rs_busy(rs_busy_c), .rd0_w(rd0_w_c), .rd0(rd0_c), .rd0_in(rd0_in_c),
    .rd1_w(rd1_w_c), .rd1(rd1_c), .rd1_in(rd1_in_c), .alloc_w(alloc_w_c),
    .alloc_rd(alloc_rd_c)
  );

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_ab();
    rd0_w   = 1'b0;
    rd1_w   = 1'b0;
    alloc_w = 1'b0;
  endtask

  // Counts rising edges until dut_a reports ready; bounded so a stuck
  // clear engine shows up as a wrong count instead of a hang.
  task automatic wait_ready(input string tag, input int exp_n);
    int n = 0;
    while (ready_a !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 64'(n), 64'(exp_n));
    chk({tag, "_b"}, 64'(ready_b), 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Power-up reset, then the full clear sequence.
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_ready_a", 64'(ready_a), 64'd0);
    chk("rst_ready_b", 64'(ready_b), 64'd0);
    rs_ab = {5'd31, 5'd9};
    #1;
    chk("rst_rs_out_a", rs_out_a, 64'd0);
    chk("rst_rs_busy_a", 64'(rs_busy_a), 64'd0);
    wait_ready("clear_len", 31);

    // Reassert reset once the clear index has reached 10.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("mid_clear_ready", 64'(ready_a), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    wait_ready("restart_len", 31);

    // Dual write collision: port 1 wins, forwarded same cycle in dut_a.
    rd0_w = 1'b1; rd0 = 5'd5; rd0_in = 32'hAAAA0000;
    rd1_w = 1'b1; rd1 = 5'd5; rd1_in = 32'h5555FFFF;
    rs_ab = {5'd0, 5'd5};
    #1;
    chk("dual_byp_a", rs_out_a[31:0], 64'h5555FFFF);
    chk("dual_byp_b", rs_out_b[31:0], 64'h0);
    tick();
    idle_ab();
    #1;
    chk("dual_a", rs_out_a[31:0], 64'h5555FFFF);
    chk("dual_b", rs_out_b[31:0], 64'h5555FFFF);

    // Writes to register 0 are dropped and never forwarded.
    rd0_w = 1'b1; rd0 = 5'd0; rd0_in = 32'hFFFFFFFF;
    rs_ab = {5'd0, 5'd5};
    #1;
    chk("r0_byp_a", rs_out_a[63:32], 64'h0);
    tick();
    idle_ab();
    #1;
    chk("r0_a", rs_out_a[63:32], 64'h0);
    chk("r0_b", rs_out_b[63:32], 64'h0);

    // Bypass: seed reg 7, then overwrite while reading it.
    rd1_w = 1'b1; rd1 = 5'd7; rd1_in = 32'hDEADBEEF;
    tick();
    idle_ab();
    rd0_w = 1'b1; rd0 = 5'd7; rd0_in = 32'h12345678;
    rs_ab = {5'd5, 5'd7};
    #1;
    chk("byp_a", rs_out_a[31:0], 64'h12345678);
    chk("byp_b_old", rs_out_b[31:0], 64'hDEADBEEF);
    chk("byp_other_port", rs_out_a[63:32], 64'h5555FFFF);
    tick();
    idle_ab();
    #1;
    chk("byp_b_new", rs_out_b[31:0], 64'h12345678);

    // Scoreboard: alloc, retire by write, alloc+write on one edge.
    alloc_w = 1'b1; alloc_rd = 5'd3;
    rs_ab = {5'd3, 5'd3};
    #1;
    chk("alloc_same_cycle", 64'(rs_busy_a), 64'd0);
    tick();
    idle_ab();
    #1;
    chk("alloc_busy_a", 64'(rs_busy_a), 64'd3);
    chk("alloc_busy_b", 64'(rs_busy_b), 64'd3);
    rd1_w = 1'b1; rd1 = 5'd3; rd1_in = 32'h00000033;
    #1;
    chk("retire_byp_busy_a", 64'(rs_busy_a), 64'd0);
    chk("retire_byp_busy_b", 64'(rs_busy_b), 64'd3);
    tick();
    idle_ab();
    #1;
    chk("retire_busy_b", 64'(rs_busy_b), 64'd0);
    chk("retire_data_b", rs_out_b[31:0], 64'h33);
    alloc_w = 1'b1; alloc_rd = 5'd3;
    rd0_w = 1'b1; rd0 = 5'd3; rd0_in = 32'h00000044;
    #1;
    chk("both_byp_busy_a", 64'(rs_busy_a), 64'd3);
    tick();
    idle_ab();
    #1;
    chk("both_busy_b", 64'(rs_busy_b), 64'd3);
    chk("both_data_b", rs_out_b[31:0], 64'h44);
    chk("both_data_a", rs_out_a[63:32], 64'h44);

    // Writes presented during CLEAR must be ignored; reset clears busy.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd0_w = 1'b1; rd0 = 5'd9; rd0_in = 32'hCAFEF00D;
    alloc_w = 1'b1; alloc_rd = 5'd9;
    #1;
    chk("clr_ready", 64'(ready_a), 64'd0);
    chk("clr_rs_out", rs_out_b, 64'd0);
    chk("clr_rs_busy", 64'(rs_busy_b), 64'd0);
    tick();
    idle_ab();
    #1;
    wait_ready("clear_len2", 30);
    rs_ab = {5'd9, 5'd3};
    #1;
    chk("post_clr_data_a", rs_out_a, 64'd0);
    chk("post_clr_busy_b", 64'(rs_busy_b), 64'd0);
    chk("post_clr_data_b", rs_out_b, 64'd0);

    // dut_c: contents retained across reset, four independent ports.
    rst_c = 1'b0;
    rd0_w_c = 1'b1; rd0_c = 4'd1;  rd0_in_c = 32'h00000011;
    rd1_w_c = 1'b1; rd1_c = 4'd14; rd1_in_c = 32'hA5A50001;
    tick();
    rd0_c = 4'd7;  rd0_in_c = 32'h12340007;
    rd1_c = 4'd15; rd1_in_c = 32'hFFFF000F;
    tick();
    rd0_w_c = 1'b0;
    rd1_w_c = 1'b0;
    rst_c = 1'b1;
    tick();
    rst_c = 1'b0;
    #1;
    chk("c_ready", 64'(ready_c), 64'd1);
    rs_c = {4'd1, 4'd14, 4'd7, 4'd15};
    #1;
    chk("c_p0", rs_out_c[31:0],   64'hFFFF000F);
    chk("c_p1", rs_out_c[63:32],  64'h12340007);
    chk("c_p2", rs_out_c[95:64],  64'hA5A50001);
    chk("c_p3", rs_out_c[127:96], 64'h00000011);
    rs_c = {4'd0, 4'd14, 4'd15, 4'd7};
    #1;
    chk("c2_p0", rs_out_c[31:0],   64'h12340007);
    chk("c2_p1", rs_out_c[63:32],  64'hFFFF000F);
    chk("c2_p2", rs_out_c[95:64],  64'hA5A50001);
    chk("c2_p3", rs_out_c[127:96], 64'h0);
    chk("c2_busy", 64'(rs_busy_c), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
